// File: rtl/thor2022_operand_fetch_pkg.sv
// Shared types and constants for the Thor2022 operand-fetch slice.
// Holds the operand-slot state enum, the slot record and the map/REB constants.
// Imported by thor2022_opr_slot and thor2022_operand_fetch.
package Thor2022_pkg;

  localparam int REB_ENTRIES = 8;
  localparam int NREGS       = 64;
  localparam int WID         = 64;
  localparam int ID_W        = 3;

  // Decode-port id meaning "no instruction this cycle".
  localparam logic [ID_W-1:0] ID_NONE  = 3'd7;
  // Source-map value meaning "value lives in the register file".
  localparam logic [5:0]      TAG_NONE = 6'd31;

  typedef enum logic [1:0] {
    OPR_EMPTY = 2'd0,
    OPR_WAIT  = 2'd1,
    OPR_READY = 2'd2
  } eOprState;

  typedef struct packed {
    eOprState        state;
    logic [ID_W-1:0] tag;
    logic [WID-1:0]  val;
  } sOperandSlot;

  localparam sOperandSlot SLOT_RESET = '{state: OPR_EMPTY, tag: '0, val: '0};

endpackage

// File: rtl/thor2022_opr_slot.sv
// One operand slot of one REB entry: capture, two-bus wake-up, flush and free.
// Ports: cap_vld/cap_slot load a resolved operand; res0/res1 snoop result buses;
//        flush/free empty the slot; rdy/val present the operand to issue.
// Optional THOR_OPR_WAKEUP_BYPASS_EN: rdy/val also reflect same-cycle bus hits.
module thor2022_opr_slot
  import Thor2022_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cap_vld,
  input  sOperandSlot     cap_slot,
  input  logic            res0_v,
  input  logic [ID_W-1:0] res0_id,
  input  logic [WID-1:0]  res0_val,
  input  logic            res1_v,
  input  logic [ID_W-1:0] res1_id,
  input  logic [WID-1:0]  res1_val,
  input  logic            flush,
  input  logic            free,
  output logic            rdy,
  output logic [WID-1:0]  val
);

  sOperandSlot slot_q, slot_d;
  logic        hit0, hit1;

  assign hit0 = (slot_q.state == OPR_WAIT) && res0_v && (res0_id == slot_q.tag);
  assign hit1 = (slot_q.state == OPR_WAIT) && res1_v && (res1_id == slot_q.tag);

  // Priority, lowest to highest: hold, wake-up, free, capture, flush.
  always_comb begin
    slot_d = slot_q;
    if (hit0) begin
      slot_d.state = OPR_READY;
      slot_d.val   = res0_val;
    end else if (hit1) begin
      slot_d.state = OPR_READY;
      slot_d.val   = res1_val;
    end
    if (free)    slot_d = SLOT_RESET;
    if (cap_vld) slot_d = cap_slot;
    if (flush)   slot_d = SLOT_RESET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= SLOT_RESET;
    else        slot_q <= slot_d;
  end

  always_comb begin
    rdy = (slot_q.state == OPR_READY);
    val = slot_q.val;
`ifdef THOR_OPR_WAKEUP_BYPASS_EN
    // Zero-cycle wake-up: present the bus value before it is latched.
    if (hit0) begin
      rdy = 1'b1;
      val = res0_val;
    end else if (hit1) begin
      rdy = 1'b1;
      val = res1_val;
    end
`endif
  end

endmodule

// File: rtl/thor2022_operand_fetch.sv
// Operand fetch after rename: resolves decode sources and fills per-REB-entry slots.
// Ports: dec0/dec1 decode lanes, regfile_src map, rf_addr/rf_data RF read, reb_done/reb_res,
//        res0/res1 result buses, branchmiss/flush_mask, issue_ack; busy/opr_rdy/opr_a/b/c out.
// Optional THOR_OPR_WAKEUP_BYPASS_EN (see thor2022_opr_slot): 0-cycle wake-up on outputs.
module thor2022_operand_fetch
  import Thor2022_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ID_W-1:0]                    dec0_id,
  input  logic [5:0]                         dec0_ra,
  input  logic [5:0]                         dec0_rb,
  input  logic [5:0]                         dec0_rc,
  input  logic [5:0]                         dec0_rt,
  input  logic                               dec0_rfwr,
  input  logic [ID_W-1:0]                    dec1_id,
  input  logic [5:0]                         dec1_ra,
  input  logic [5:0]                         dec1_rb,
  input  logic [5:0]                         dec1_rc,
  input  logic [NREGS-1:0][5:0]              regfile_src,
  output logic [5:0][5:0]                    rf_addr,
  input  logic [5:0][WID-1:0]                rf_data,
  input  logic [REB_ENTRIES-1:0]             reb_done,
  input  logic [REB_ENTRIES-1:0][WID-1:0]    reb_res,
  input  logic                               res0_v,
  input  logic [ID_W-1:0]                    res0_id,
  input  logic [WID-1:0]                     res0_val,
  input  logic                               res1_v,
  input  logic [ID_W-1:0]                    res1_id,
  input  logic [WID-1:0]                     res1_val,
  input  logic                               branchmiss,
  input  logic [REB_ENTRIES-1:0]             flush_mask,
  input  logic [REB_ENTRIES-1:0]             issue_ack,
  output logic [REB_ENTRIES-1:0]             busy,
  output logic [REB_ENTRIES-1:0]             opr_rdy,
  output logic [REB_ENTRIES-1:0][WID-1:0]    opr_a,
  output logic [REB_ENTRIES-1:0][WID-1:0]    opr_b,
  output logic [REB_ENTRIES-1:0][WID-1:0]    opr_c
);

  logic [5:0]       src_reg  [6];
  logic [5:0]       map_v    [6];
  sOperandSlot      res_slot [6];
  logic             cap0, cap1;
  logic [REB_ENTRIES-1:0] cap_e, lane1_e, flush_e;
  logic [REB_ENTRIES-1:0] busy_q, busy_d;
  logic [REB_ENTRIES-1:0][2:0] slot_rdy;
  logic [WID-1:0]   slot_val [REB_ENTRIES][3];

  // Source resolution for all six operands (lane 0 a/b/c, then lane 1 a/b/c).
  always_comb begin
    src_reg = '{dec0_ra, dec0_rb, dec0_rc, dec1_ra, dec1_rb, dec1_rc};
    for (int k = 0; k < 6; k++) begin
      map_v[k]          = regfile_src[src_reg[k]];
      rf_addr[k]        = src_reg[k];
      res_slot[k].state = OPR_WAIT;
      res_slot[k].tag   = map_v[k][2:0];
      res_slot[k].val   = '0;
      if (src_reg[k] == 6'd0) begin
        res_slot[k].state = OPR_READY;
        res_slot[k].tag   = '0;
      end else if (k >= 3 && dec0_id != ID_NONE && dec0_rfwr && src_reg[k] == dec0_rt) begin
        // Lane 0 of the same pair writes this register; the map is stale.
        res_slot[k].tag = dec0_id;
      end else if (map_v[k] == TAG_NONE) begin
        res_slot[k].state = OPR_READY;
        res_slot[k].val   = rf_data[k];
      end else if (reb_done[map_v[k][2:0]]) begin
        res_slot[k].state = OPR_READY;
        res_slot[k].val   = reb_res[map_v[k][2:0]];
      end else if (res0_v && res0_id == map_v[k][2:0]) begin
        res_slot[k].state = OPR_READY;
        res_slot[k].val   = res0_val;
      end else if (res1_v && res1_id == map_v[k][2:0]) begin
        res_slot[k].state = OPR_READY;
        res_slot[k].val   = res1_val;
      end
    end
  end

  // A flush cycle captures nothing; a lane-1 id colliding with lane 0 is dropped.
  assign cap0 = !branchmiss && (dec0_id != ID_NONE);
  assign cap1 = !branchmiss && (dec1_id != ID_NONE) && (dec1_id != dec0_id);

  always_comb begin
    for (int i = 0; i < REB_ENTRIES; i++) begin
      cap_e[i]   = 1'b0;
      lane1_e[i] = 1'b0;
      if (cap0 && dec0_id == ID_W'(i)) begin
        cap_e[i] = 1'b1;
      end else if (cap1 && dec1_id == ID_W'(i)) begin
        cap_e[i]   = 1'b1;
        lane1_e[i] = 1'b1;
      end
      flush_e[i] = branchmiss && flush_mask[i];
      busy_d[i]  = busy_q[i];
      if (issue_ack[i]) busy_d[i] = 1'b0;
      if (cap_e[i])     busy_d[i] = 1'b1;
      if (flush_e[i])   busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar i = 0; i < REB_ENTRIES; i++) begin : g_ent
    for (genvar j = 0; j < 3; j++) begin : g_opr
      thor2022_opr_slot u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap_vld  (cap_e[i]),
        .cap_slot (lane1_e[i] ? res_slot[3+j] : res_slot[j]),
        .res0_v   (res0_v),
        .res0_id  (res0_id),
        .res0_val (res0_val),
        .res1_v   (res1_v),
        .res1_id  (res1_id),
        .res1_val (res1_val),
        .flush    (flush_e[i]),
        .free     (issue_ack[i]),
        .rdy      (slot_rdy[i][j]),
        .val      (slot_val[i][j])
      );
    end
    assign opr_rdy[i] = busy_q[i] & (&slot_rdy[i]);
    assign opr_a[i]   = slot_val[i][0];
    assign opr_b[i]   = slot_val[i][1];
    assign opr_c[i]   = slot_val[i][2];
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_thor2022_operand_fetch.sv
// Directed bench for thor2022_operand_fetch (default build, registered wake-up).
module tb_thor2022_operand_fetch;
  import Thor2022_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic [2:0]                      dec0_id, dec1_id;
  logic [5:0]                      dec0_ra, dec0_rb, dec0_rc, dec0_rt;
  logic                            dec0_rfwr;
  logic [5:0]                      dec1_ra, dec1_rb, dec1_rc;
  logic [NREGS-1:0][5:0]           regfile_src;
  logic [5:0][5:0]                 rf_addr;
  logic [5:0][WID-1:0]             rf_data;
  logic [REB_ENTRIES-1:0]          reb_done;
  logic [REB_ENTRIES-1:0][WID-1:0] reb_res;
  logic                            res0_v, res1_v;
  logic [2:0]                      res0_id, res1_id;
  logic [WID-1:0]                  res0_val, res1_val;
  logic                            branchmiss;
  logic [REB_ENTRIES-1:0]          flush_mask, issue_ack;
  logic [REB_ENTRIES-1:0]          busy, opr_rdy;
  logic [REB_ENTRIES-1:0][WID-1:0] opr_a, opr_b, opr_c;

  int nchk  = 0;
  int nfail = 0;

  thor2022_operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .dec0_id(dec0_id), .dec0_ra(dec0_ra), .dec0_rb(dec0_rb), .dec0_rc(dec0_rc),
    .dec0_rt(dec0_rt), .dec0_rfwr(dec0_rfwr),
    .dec1_id(dec1_id), .dec1_ra(dec1_ra), .dec1_rb(dec1_rb), .dec1_rc(dec1_rc),
    .regfile_src(regfile_src), .rf_addr(rf_addr), .rf_data(rf_data),
    .reb_done(reb_done), .reb_res(reb_res),
    .res0_v(res0_v), .res0_id(res0_id), .res0_val(res0_val),
    .res1_v(res1_v), .res1_id(res1_id), .res1_val(res1_val),
    .branchmiss(branchmiss), .flush_mask(flush_mask), .issue_ack(issue_ack),
    .busy(busy), .opr_rdy(opr_rdy), .opr_a(opr_a), .opr_b(opr_b), .opr_c(opr_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec0_id = 3'd7; dec0_ra = '0; dec0_rb = '0; dec0_rc = '0; dec0_rt = '0; dec0_rfwr = 1'b0;
    dec1_id = 3'd7; dec1_ra = '0; dec1_rb = '0; dec1_rc = '0;
    res0_v = 1'b0; res0_id = '0; res0_val = '0;
    res1_v = 1'b0; res1_id = '0; res1_val = '0;
    branchmiss = 1'b0; flush_mask = '0; issue_ack = '0;
  endtask

  initial begin
    idle();
    for (int r = 0; r < NREGS; r++) regfile_src[r] = 6'd31;
    rf_data = '0; reb_done = '0; reb_res = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset held with a capture presented.
    dec0_id = 3'd2; dec0_ra = 6'd5; rf_data[0] = 64'h1234;
    tick(); tick();
    chk("rst_busy", {56'd0, busy}, 64'd0);
    chk("rst_opr_rdy", {56'd0, opr_rdy}, 64'd0);
    chk("rst_opr_a_any", {63'd0, |opr_a}, 64'd0);

    // Release reset: capture from the register file into entry 2.
    rst_n = 1'b1;
    tick();
    idle();
    chk("rf_busy2", {63'd0, busy[2]}, 64'd1);
    chk("rf_opr_a2", opr_a[2], 64'h1234);
    chk("rf_rdy2", {63'd0, opr_rdy[2]}, 64'd1);

    // Entry 1 waits on tag 4; woken by res1 two cycles later.
    dec0_id = 3'd1; dec0_ra = 6'd7; regfile_src[7] = 6'd4;
    #1;
    chk("rf_addr0", {58'd0, rf_addr[0]}, 64'd7);
    tick();
    idle();
    chk("wait_busy1", {63'd0, busy[1]}, 64'd1);
    chk("wait_rdy1", {63'd0, opr_rdy[1]}, 64'd0);
    tick();
    chk("wait_rdy1_hold", {63'd0, opr_rdy[1]}, 64'd0);
    res1_v = 1'b1; res1_id = 3'd4; res1_val = 64'hAA;
    tick();
    idle();
    chk("wake_rdy1", {63'd0, opr_rdy[1]}, 64'd1);
    chk("wake_opr_a1", opr_a[1], 64'hAA);

    // Intra-pair bypass: lane 1 rb=9 waits on lane 0 (entry 3).
    dec0_id = 3'd3; dec0_rt = 6'd9; dec0_rfwr = 1'b1;
    dec1_id = 3'd4; dec1_rb = 6'd9; rf_data[4] = 64'hDEAD;
    tick();
    idle();
    chk("pair_busy3", {63'd0, busy[3]}, 64'd1);
    chk("pair_rdy3", {63'd0, opr_rdy[3]}, 64'd1);
    chk("pair_busy4", {63'd0, busy[4]}, 64'd1);
    chk("pair_rdy4", {63'd0, opr_rdy[4]}, 64'd0);
    chk("pair_opr_b4", opr_b[4], 64'd0);
    res0_v = 1'b1; res0_id = 3'd3; res0_val = 64'h55;
    tick();
    idle();
    chk("pair_wake_b4", opr_b[4], 64'h55);
    chk("pair_wake_rdy4", {63'd0, opr_rdy[4]}, 64'd1);

    // Both buses match tag 6: res0 wins.
    dec0_id = 3'd0; dec0_ra = 6'd10; regfile_src[10] = 6'd6;
    tick();
    idle();
    chk("dual_rdy0_pre", {63'd0, opr_rdy[0]}, 64'd0);
    res0_v = 1'b1; res0_id = 3'd6; res0_val = 64'h1;
    res1_v = 1'b1; res1_id = 3'd6; res1_val = 64'h2;
    tick();
    idle();
    chk("dual_opr_a0", opr_a[0], 64'h1);
    chk("dual_rdy0", {63'd0, opr_rdy[0]}, 64'd1);

    // Flush entry 5 in the same cycle as its wake-up; capture to 4 suppressed.
    dec0_id = 3'd5; dec0_ra = 6'd11; regfile_src[11] = 6'd2;
    tick();
    idle();
    chk("fl_busy5_pre", {63'd0, busy[5]}, 64'd1);
    chk("fl_rdy5_pre", {63'd0, opr_rdy[5]}, 64'd0);
    branchmiss = 1'b1; flush_mask = 8'h20;
    res0_v = 1'b1; res0_id = 3'd2; res0_val = 64'h77;
    dec0_id = 3'd4;
    tick();
    idle();
    chk("fl_busy5", {63'd0, busy[5]}, 64'd0);
    chk("fl_rdy5", {63'd0, opr_rdy[5]}, 64'd0);
    chk("fl_busy4", {63'd0, busy[4]}, 64'd1);
    chk("fl_rdy4", {63'd0, opr_rdy[4]}, 64'd1);
    chk("fl_opr_b4", opr_b[4], 64'h55);

    // r0 operands are ready with value 0; issue_ack frees the entry.
    dec0_id = 3'd6;
    tick();
    idle();
    chk("r0_rdy6", {63'd0, opr_rdy[6]}, 64'd1);
    chk("r0_vals6", opr_a[6] | opr_b[6] | opr_c[6], 64'd0);
    issue_ack = 8'h40;
    tick();
    idle();
    chk("ack_busy6", {63'd0, busy[6]}, 64'd0);
    chk("ack_rdy6", {63'd0, opr_rdy[6]}, 64'd0);

    // issue_ack and capture on the same entry: capture wins.
    issue_ack = 8'h04; dec0_id = 3'd2; dec0_ra = 6'd5; rf_data[0] = 64'h99;
    tick();
    idle();
    chk("ackcap_busy2", {63'd0, busy[2]}, 64'd1);
    chk("ackcap_opr_a2", opr_a[2], 64'h99);

    // Lane 0 from a finished REB entry, lane 1 from a same-cycle res1 hit.
    dec0_id = 3'd1; dec0_ra = 6'd12; regfile_src[12] = 6'd5;
    reb_done[5] = 1'b1; reb_res[5] = 64'hBEEF;
    dec1_id = 3'd0; dec1_ra = 6'd13; regfile_src[13] = 6'd3;
    res1_v = 1'b1; res1_id = 3'd3; res1_val = 64'h33;
    tick();
    idle();
    chk("reb_opr_a1", opr_a[1], 64'hBEEF);
    chk("reb_rdy1", {63'd0, opr_rdy[1]}, 64'd1);
    chk("bus_opr_a0", opr_a[0], 64'h33);
    chk("bus_rdy0", {63'd0, opr_rdy[0]}, 64'd1);

    // Duplicate id: lane 1 ignored, entry 3 takes lane 0's all-r0 operands.
    dec0_id = 3'd3;
    dec1_id = 3'd3; dec1_ra = 6'd14; regfile_src[14] = 6'd1;
    tick();
    idle();
    chk("dup_rdy3", {63'd0, opr_rdy[3]}, 64'd1);

    // Asynchronous reset mid-cycle discards everything before the next edge.
    rst_n = 1'b0;
    #2;
    chk("arst_busy", {56'd0, busy}, 64'd0);
    chk("arst_opr_rdy", {56'd0, opr_rdy}, 64'd0);
    chk("arst_opr_any", {63'd0, |{opr_a, opr_b, opr_c}}, 64'd0);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/thor2022_operand_fetch.md
Name: thor2022_operand_fetch

Overview:
- Consumer side of register renaming: reads the per-register source map produced at decode and fills operand slots for each reorder-buffer (REB) entry.
- Captures an operand from one of three places: the register file, a finished REB result, or a tag to wait on.
- Snoops two result buses to wake up waiting operands.
- Sits between decode/rename and issue; issue selects entries whose opr_rdy is set.

Parameters:
- REB_ENTRIES, 8: number of REB entries; index width is 3, and index 7 on a decode port means "no instruction".
- NREGS, 64: architectural registers.
- WID, 64: operand data width.
- TAG_NONE, 6'd31: source-map value meaning "value is in the register file".

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec0_id  in  3  REB slot of decode lane 0; 7 = none.
- dec0_ra, dec0_rb, dec0_rc  in  6 each  lane-0 source registers.
- dec0_rt  in  6  lane-0 target register.
- dec0_rfwr  in  1  lane-0 writes dec0_rt.
- dec1_id  in  3  REB slot of decode lane 1; 7 = none.
- dec1_ra, dec1_rb, dec1_rc  in  6 each  lane-1 source registers.
- regfile_src  in  NREGS x 6  current source map.
- rf_addr  out  6 x 6  combinational register-file read addresses, in lane/operand order a, b, c.
- rf_data  in  6 x WID  asynchronous read data for rf_addr.
- reb_done  in  REB_ENTRIES  entry has a result.
- reb_res  in  REB_ENTRIES x WID  entry results.
- res0_v, res1_v  in  1 each  result bus valid.
- res0_id, res1_id  in  3 each  producing REB entry.
- res0_val, res1_val  in  WID each  result data.
- branchmiss  in  1  flush strobe.
- flush_mask  in  REB_ENTRIES  entries to discard when branchmiss is high.
- issue_ack  in  REB_ENTRIES  entry issued; frees its slots.
- busy  out  REB_ENTRIES  entry holds a captured instruction.
- opr_rdy  out  REB_ENTRIES  busy and all three operands ready.
- opr_a, opr_b, opr_c  out  REB_ENTRIES x WID  operand values.

Behaviour:
- Operand slot state is one of EMPTY, WAIT, or READY; each slot also holds a 3-bit tag and a WID-bit value.
- Reset (rst_n low, asynchronous): every slot goes EMPTY with tag 0 and value 0. busy, opr_rdy, and opr_a/b/c are all 0. rst_n low mid-operation discards every entry immediately.
- Capture occurs on the clock edge where decN_id != 7. Each source register r resolves in this priority order:
  1. r == 0: READY, value 0.
  2. Lane 1 only: dec0_id != 7, dec0_rfwr, and r == dec0_rt: WAIT with tag dec0_id. This is the intra-pair bypass; it overrides the map.
  3. regfile_src[r] == TAG_NONE: READY with rf_data.
  4. reb_done[src]: READY with reb_res[src].
  5. A result bus this cycle with id == src: READY with that bus value; res0 has priority over res1.
  6. Otherwise: WAIT with tag src[2:0].
- Wake-up: a WAIT slot whose tag matches resN_id while resN_v is high becomes READY next edge and latches the bus value. If both buses match, res0 wins.
- Latency: capture or wake-up at edge N gives opr_rdy visible after edge N; registered, 1 cycle.
- issue_ack[i]: entry i goes EMPTY next edge. If issue_ack and capture target the same entry in the same cycle, capture wins.
- branchmiss: every entry with flush_mask set goes EMPTY. Flush beats capture and wake-up for that entry. While branchmiss is high, capture is suppressed and any decN_id is ignored.
- Capture of an id that is already busy overwrites the entry; decode guarantees this is legal.
- dec0_id == dec1_id (both != 7) is illegal; lane 1 is ignored.
- Tag width is 3 bits; the upper bits of regfile_src are ignored except for the TAG_NONE compare.

Optional Feature:
- THOR_OPR_WAKEUP_BYPASS_EN defined: opr_rdy[i] and opr_a/b/c[i] also reflect same-cycle bus matches for WAIT slots, combinationally. This gives 0-cycle wake-up; state still updates at the edge.
- Undefined: outputs come purely from registered state, with 1-cycle wake-up.

Decomposition:
- The shared package (Thor2022_pkg) holds:
  - enum eOprState {OPR_EMPTY, OPR_WAIT, OPR_READY};
  - struct sOperandSlot {state, tag[2:0], val[WID-1:0]};
  - constant TAG_NONE.
- Sub-module thor2022_opr_slot: one slot, covering capture, wake-up on two buses, flush, and free. It is instantiated REB_ENTRIES x 3 times.

Test Plan:
- rst_n low with capture active -> busy=0, opr_rdy=0, opr_a=0 all entries. Release rst_n, dec0_id=2, ra=5 with regfile_src[5]=31 and rf_data=0x1234 -> next cycle busy[2]=1, opr_a[2]=0x1234.
- dec0_id=1, ra=7, regfile_src[7]=4, reb_done[4]=0 -> opr_rdy[1]=0. Two cycles later res1_v=1, res1_id=4, res1_val=0xAA -> next cycle opr_rdy[1]=1, opr_a[1]=0xAA.
- Lane pair: dec0_id=3, dec0_rt=9, dec0_rfwr=1; dec1_id=4, dec1_rb=9, regfile_src[9]=31 -> slot b of entry 4 is WAIT on tag 3, not rf_data. Then res0_id=3, res0_val=0x55 -> opr_b[4]=0x55.
- Both buses with id 6, res0_val=0x1 and res1_val=0x2, while entry 0 waits on tag 6 -> opr_a[0]=0x1.
- Entry 5 in WAIT, then branchmiss=1 with flush_mask=0x20 in the same cycle as a res0 match -> busy[5]=0 and opr_rdy[5]=0. Entry 4, not masked, unaffected.
- ra=0, rb=0, rc=0 capture into entry 6 -> opr_rdy[6]=1 next cycle with all values 0. issue_ack[6] -> busy[6]=0 the following cycle.
